// File: rtl/uart_echo_tester.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_echo_tester                                           |
// | Description : Byte-level initiator for the UART echo path. Sends an      |
// |               8-bit LFSR byte stream to uart_tx, compares each echoed    |
// |               byte from uart_rx, and reports sent/error/pass status.     |
// |               Optional build macro UART_ECHO_STRAY_CHECK_EN: a byte      |
// |               received while waiting to send counts as one error.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_echo_tester #(
  parameter int         CLK_FREQ  = 25_000_000,
  parameter int         BAUD_RATE = 115_200,
  parameter int         NUM_BYTES = 256,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_busy,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [15:0] o_err_count,
  output logic [15:0] o_sent_count
);

  // Three frame times of ten bits each; clamped so a degenerate clock/baud
  // ratio still gives a usable one-cycle timeout.
  localparam int c_timeout_raw = 30 * (CLK_FREQ / BAUD_RATE);
  localparam int c_timeout     = (c_timeout_raw < 1) ? 1 : c_timeout_raw;
  localparam int c_timer_w     = $clog2(c_timeout + 1);

  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(c_timeout - 1);
  localparam logic [c_timer_w-1:0] c_timer_one  = c_timer_w'(1);
  localparam logic [7:0]           c_seed       = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0]          c_num_bytes  = 16'(NUM_BYTES);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_send = 2'd1;
  localparam logic [1:0] c_st_wait = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  logic [1:0]           r_state;
  logic [7:0]           r_lfsr;
  logic [c_timer_w-1:0] r_timer;
  logic                 r_tx_valid;
  logic [7:0]           r_tx_data;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [15:0]          r_err_count;
  logic [15:0]          r_sent_count;

  logic [7:0]  w_lfsr_next;
  logic [15:0] w_err_inc;
  logic [15:0] w_sent_next;
  logic        w_timeout;
  logic        w_byte_done;
  logic        w_byte_err;

  // Next-value helpers: LFSR step, saturating error increment, byte outcome.
  always_comb begin
    w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    w_err_inc   = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;
    w_sent_next = r_sent_count + 16'd1;
    w_timeout   = (r_timer == c_timer_last);
    w_byte_done = i_rx_valid || w_timeout;
    // A received byte wins over a simultaneous timeout.
    w_byte_err  = i_rx_valid ? (i_rx_data != r_lfsr) : 1'b1;
  end

  // Run sequencer: start, send one byte, await echo or timeout, repeat.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= c_st_idle;
      r_lfsr       <= c_seed;
      r_timer      <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= 16'h0000;
      r_sent_count <= 16'h0000;
    end else begin
      r_tx_valid <= 1'b0;
      case (r_state)
        c_st_idle, c_st_done: begin
          if (i_start) begin
            r_lfsr       <= c_seed;
            r_timer      <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= 16'h0000;
            r_sent_count <= 16'h0000;
            r_state      <= c_st_send;
          end
        end
        c_st_send: begin
`ifdef UART_ECHO_STRAY_CHECK_EN
          // Unsolicited or duplicated echo: counted and dropped.
          if (i_rx_valid) begin
            r_err_count <= w_err_inc;
          end
`endif
          if (!i_tx_busy) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_lfsr;
            r_timer    <= '0;
            r_state    <= c_st_wait;
          end
        end
        c_st_wait: begin
          r_timer <= r_timer + c_timer_one;
          if (w_byte_done) begin
            if (w_byte_err) begin
              r_err_count <= w_err_inc;
            end
            r_lfsr       <= w_lfsr_next;
            r_sent_count <= w_sent_next;
            if (w_sent_next == c_num_bytes) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (r_err_count == 16'h0000) && !w_byte_err;
              r_state <= c_st_done;
            end else begin
              r_state <= c_st_send;
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign o_tx_valid   = r_tx_valid;
  assign o_tx_data    = r_tx_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_err_count  = r_err_count;
  assign o_sent_count = r_sent_count;

endmodule
`default_nettype wire
